// File: rtl/cla_pkg.sv
// cla_pkg: shared group types and 4-bit lookahead helpers for the pipelined CLA
package cla_pkg;
    localparam int GRP_W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    function automatic int grpCount(input int w);
        return w / GRP_W;
    endfunction

    function automatic grp_pg_t grpPg(input logic [GRP_W-1:0] p, input logic [GRP_W-1:0] g);
        return '{p: &p, g: g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]};
    endfunction

    // carries into bits 0..3 of a group; bit 3's own P/G only feed the group terms
    function automatic logic [GRP_W-1:0] grpCarries(input logic [GRP_W-2:0] p, input logic [GRP_W-2:0] g, input logic c);
        return {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c,
                g[1] | p[1] & g[0] | p[1] & p[0] & c,
                g[0] | p[0] & c,
                c};
    endfunction
endpackage

// File: rtl/cla_pipe_addsub_slice.sv
// cla_slice: combinational SW-bit carry-lookahead slice built from 4-bit groups
module cla_slice
    import cla_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);
    localparam int NG = grpCount(SW);
    logic [SW-1:0] p, g, c;
    logic [NG:0] gc;
    grp_pg_t grp [NG];
    assign p = a ^ b;
    assign g = a & b;
    assign gc[0] = cin;
    for (genvar j = 0; j < NG; j++) begin : grpGen
        assign grp[j] = grpPg(p[j*GRP_W +: GRP_W], g[j*GRP_W +: GRP_W]);
        assign gc[j+1] = grp[j].g | (grp[j].p & gc[j]);
        assign c[j*GRP_W +: GRP_W] = grpCarries(p[j*GRP_W +: GRP_W-1], g[j*GRP_W +: GRP_W-1], gc[j]);
    end
    assign sum = p ^ c;
    assign cout = gc[NG];
    assign cmsb = c[SW-1];
endmodule

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: STAGES-deep pipelined carry-lookahead adder/subtractor
// with valid/ready backpressure and carry/overflow/zero flags.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int SW = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}});
    logic advance;
    logic [STAGES-1:0] vQ, vNext;
    // accQ[k]: finished sum bits for slices 0..k, untouched A bits above them
    logic [WIDTH-1:0] accQ [STAGES];
    logic [WIDTH-1:0] accD [STAGES];
    logic [WIDTH-1:0] bQ [STAGES];
    logic [WIDTH-1:0] bD [STAGES];
    logic cQ [STAGES];
    logic coD [STAGES];
    logic cmD [STAGES];
    logic coutQ, ovfQ, zeroQ;
    assign advance = !out_valid || out_ready;
    assign in_ready = advance;
    assign vNext = STAGES'({vQ, in_valid});
    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic [WIDTH-1:0] accIn;
        logic [SW-1:0] sliceSum;
        logic cIn;
        if (k == 0) begin : head
            assign accIn = in_a;
            assign bD[k] = in_b ^ {WIDTH{in_sub}};
            assign cIn = in_sub ^ in_cin;
        end else begin : body
            assign accIn = accQ[k-1];
            assign bD[k] = bQ[k-1];
            assign cIn = cQ[k-1];
        end
        cla_slice #(.SW(SW)) sliceInst (
            .a(accIn[k*SW +: SW]),
            .b(bD[k][k*SW +: SW]),
            .cin(cIn),
            .sum(sliceSum),
            .cout(coD[k]),
            .cmsb(cmD[k])
        );
        assign accD[k] = (accIn & ~(SLICE_MASK << (k*SW))) | (WIDTH'(sliceSum) << (k*SW));
    end
    // the output stage only loads real results, so it reads zero until the first one
    always_ff @(posedge clk) begin
        if (rst) begin
            vQ <= '0;
            accQ[LAST] <= '0;
            coutQ <= 1'b0;
            ovfQ <= 1'b0;
            zeroQ <= 1'b0;
        end else if (advance) begin
            vQ <= vNext;
            for (int k = 0; k < STAGES; k++) begin
                bQ[k] <= bD[k];
                cQ[k] <= coD[k];
                if (k < LAST) accQ[k] <= accD[k];
            end
            if (vNext[LAST]) begin
                accQ[LAST] <= accD[LAST];
                coutQ <= coD[LAST];
                ovfQ <= cmD[LAST] ^ coD[LAST];
                zeroQ <= accD[LAST] == '0;
            end
        end
    end
    assign out_valid = vQ[LAST];
    assign out_sum = accQ[LAST];
    assign out_cout = coutQ;
    assign out_ovf = ovfQ;
    assign out_zero = zeroQ;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: scoreboard bench for three configs (16/4, 32/2, 8/1)
// checked against a signed/unsigned arithmetic reference model.
module tb_cla_pipe_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] iv = '0, icin = '0, isub = '0, ordy = '1;
    logic [2:0] irdy, ov, oc, oo, oz;
    logic [31:0] ia [3];
    logic [31:0] ib [3];
    logic [31:0] osum [3];
    logic [15:0] s0;
    logic [31:0] s1;
    logic [7:0] s2;
    logic [34:0] expq [3][$];
    int xfer [3] = '{0, 0, 0};
    int passCnt = 0, totalCnt = 0;
    bit stopRdy;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(16), .STAGES(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_a(ia[0][15:0]), .in_b(ib[0][15:0]),
        .in_cin(icin[0]), .in_sub(isub[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s0),
        .out_cout(oc[0]), .out_ovf(oo[0]), .out_zero(oz[0]));
    cla_pipe_addsub #(.WIDTH(32), .STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_a(ia[1]), .in_b(ib[1]),
        .in_cin(icin[1]), .in_sub(isub[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s1),
        .out_cout(oc[1]), .out_ovf(oo[1]), .out_zero(oz[1]));
    cla_pipe_addsub #(.WIDTH(8), .STAGES(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_a(ia[2][7:0]), .in_b(ib[2][7:0]),
        .in_cin(icin[2]), .in_sub(isub[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s2),
        .out_cout(oc[2]), .out_ovf(oo[2]), .out_zero(oz[2]));

    always_comb begin
        osum[0] = 32'(s0);
        osum[1] = s1;
        osum[2] = 32'(s2);
    end

    function automatic int wOf(int d);
        return d == 0 ? 16 : d == 1 ? 32 : 8;
    endfunction

    // expected {ovf, zero, cout, sum}: exact unsigned and signed results, then range checks
    function automatic logic [34:0] model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        longint full = longint'(1) << w;
        longint half = full >> 1;
        longint ua = longint'(a) & (full - 1);
        longint ub = longint'(b) & (full - 1);
        longint sa = ua >= half ? ua - full : ua;
        longint sb = ub >= half ? ub - full : ub;
        longint ci = longint'(cin);
        longint r = sub ? ua - ub - ci : ua + ub + ci;
        longint sr = sub ? sa - sb - ci : sa + sb + ci;
        logic cout = sub ? r >= 0 : r >= full;
        longint sum = r & (full - 1);
        return {sr < -half || sr >= half, sum == 0, cout, 32'(sum)};
    endfunction

    function automatic logic [31:0] rnd(int d);
        logic [31:0] m = 32'hFFFF_FFFF >> (32 - wOf(d));
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return m;
            2: return (m >> 1) + 1;
            3: return m >> 1;
            default: return $urandom & m;
        endcase
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        totalCnt++;
        if (got === want) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic send(int d, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        bit acc = 0;
        int t = 0;
        iv[d] = 1'b1;
        ia[d] = a;
        ib[d] = b;
        icin[d] = cin;
        isub[d] = sub;
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = irdy[d];
            if (acc) expq[d].push_back(model(wOf(d), a, b, cin, sub));
            @(posedge clk);
            #1;
            t++;
        end
        iv[d] = 1'b0;
        if (!acc) check($sformatf("accept dut%0d", d), 64'(acc), 64'd1);
    endtask

    task automatic directed(string name, logic [15:0] a, logic [15:0] b, logic cin, logic sub, logic [34:0] want);
        int n = 1;
        send(0, 32'(a), 32'(b), cin, sub);
        @(negedge clk);
        while (!ov[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 64'(n), 64'd4);
        check({name, " result"}, 64'({oo[0], oz[0], oc[0], osum[0]}), 64'(want));
        @(posedge clk);
        #1;
    endtask

    task automatic randOps(int d, int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ia[d] = $urandom;
                ib[d] = $urandom;
                @(posedge clk);
                #1;
            end
            send(d, rnd(d), rnd(d), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && ordy[d]) begin
                    xfer[d]++;
                    if (expq[d].size() == 0) check($sformatf("spurious out dut%0d", d), 64'(ov[d]), 64'd0);
                    else check($sformatf("result dut%0d", d), 64'({oo[d], oz[d], oc[d], osum[d]}), 64'(expq[d].pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d done", passCnt, totalCnt);
        $fatal(1);
    end

    initial begin
        int base;
        for (int d = 0; d < 3; d++) begin
            ia[d] = '0;
            ib[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset outputs dut%0d", d), 64'({ov[d], oo[d], oz[d], oc[d], osum[d]}), 64'd0);
            check($sformatf("reset in_ready dut%0d", d), 64'(irdy[d]), 64'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        directed("add wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, 32'h0000});
        directed("signed ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 32'h8000});
        directed("sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFE});
        directed("sub ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 32'h7FFF});

        base = xfer[0];
        for (int i = 0; i < 8; i++) send(0, rnd(0), rnd(0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (4) @(negedge clk);
        #1;
        check("full rate xfers", 64'(xfer[0] - base), 64'd8);
        @(posedge clk);
        #1;

        ordy[0] = 1'b0;
        base = xfer[0];
        fork
            for (int i = 0; i < 6; i++) send(0, rnd(0), rnd(0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            begin
                logic [31:0] held;
                int n;
                n = 0;
                @(negedge clk);
                while (!ov[0] && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("stall full", 64'(ov[0]), 64'd1);
                held = osum[0];
                repeat (3) begin
                    @(negedge clk);
                    check("stall in_ready", 64'(irdy[0]), 64'd0);
                    check("stall held sum", 64'(osum[0]), 64'(held));
                end
                @(posedge clk);
                #1;
                ordy[0] = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        #1;
        check("stall xfers", 64'(xfer[0] - base), 64'd6);
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) send(0, rnd(0), rnd(0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rst = 1'b1;
        expq[0].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("valid after reset", 64'(ov[0]), 64'd0);
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                seen += int'(ov[0]);
            end
            check("discarded results", 64'(seen), 64'd0);
        end
        @(posedge clk);
        #1;
        directed("post reset", 16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h5555});

        stopRdy = 1'b0;
        fork
            while (!stopRdy) begin
                @(posedge clk);
                #1;
                for (int d = 0; d < 3; d++) ordy[d] = $urandom_range(0, 3) != 0;
            end
            begin
                fork
                    randOps(0, 2000);
                    randOps(1, 10000);
                    randOps(2, 10000);
                join
                stopRdy = 1'b1;
            end
        join
        ordy = '1;
        begin
            int n;
            n = 0;
            while (expq[0].size() + expq[1].size() + expq[2].size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        #1;
        for (int d = 0; d < 3; d++) check($sformatf("drain dut%0d", d), 64'(expq[d].size()), 64'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
